wb_seq: RTL and testbench
=========================

Name: wb_seq

Overview:
- Parametrised write-back sequencer: captures one result set of NCH channel words per input handshake.
- Buffers up to DEPTH sets and serialises them into a single-port result RAM, one word per granted cycle, at consecutive addresses from a loadable base pointer.
- Sits between the multiply-unit array outputs and the result RAM write port; adds backpressure, RAM-grant stalling and a per-set completion pulse.

Parameters:
- NCH, 4, channels per result set (>=2).
- DW, 18, channel data width.
- RAMW, 32, RAM word width (>= DW).
- AW, 8, RAM address width.
- DEPTH, 2, result sets buffered (power of two, >=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  result set present on in_data.
- in_ready  out  1  sequencer can accept a set.
- in_data  in  NCH*DW  channel k at bits [k*DW+DW-1 : k*DW].
- base_load  in  1  load write pointer from base_addr.
- base_addr  in  AW  new write pointer value.
- ram_gnt  in  1  RAM accepts the current write this cycle.
- ram_en  out  1  write request.
- ram_addr  out  AW  write address.
- ram_wdata  out  RAMW  write data.
- busy  out  1  buffer non-empty or write in progress.
- done  out  1  one-cycle pulse after last word of a set is written.

Behaviour:
- Reset: state IDLE; write pointer, channel index, FIFO pointers and count cleared. Outputs: ram_en=0, ram_addr=0, ram_wdata=0, busy=0, done=0, in_ready=1.
- Accept: a set is pushed when in_valid && in_ready. in_ready = !full, combinational from count only; no same-cycle pop bypass, so a full FIFO deasserts in_ready even on a pop cycle.
- Commit: a write commits when ram_en && ram_gnt. Write pointer increments by 1 per commit, modulo 2^AW; wrap 2^AW-1 -> 0 is silent.
- FSM IDLE:
  - ram_en=0.
  - FIFO non-empty -> WRITE with channel index 0.
  - A set accepted at edge t gives first ram_en in cycle t+1.
- FSM WRITE:
  - ram_en=1; ram_addr = write pointer; ram_wdata = head set channel[idx], zero-extended to RAMW.
  - Commit with idx<NCH-1: idx+1.
  - Commit with idx==NCH-1: pop head, idx=0, done=1 next cycle. Stay in WRITE if another set remains after the pop, else IDLE.
  - No commit: all write outputs held stable until granted.
- Back-to-back sets: with ram_gnt tied high, k queued sets are written in exactly k*NCH consecutive cycles, no bubbles.
- Registered outputs: ram_en, ram_addr, ram_wdata and done. busy = (state==WRITE) || count!=0.
- base_load: honoured only in IDLE with an empty FIFO; ignored otherwise (no effect on the pointer). Load and push in the same cycle: load takes effect, and the set is written starting at base_addr.
- Channel order: channel 0 first; the address increases with channel then set.
- Reset mid-operation: buffered sets discarded, no partial completion, no done pulse.

Optional Feature:
- Macro WB_SIGN_EXT_EN.
- Defined: ram_wdata[RAMW-1:DW] replicates bit DW-1 of the channel word (sign extension of two's-complement results).
- Undefined: upper bits are zero.
- No other behaviour changes.

Test Plan:
- Reset, base_load=1 base_addr=8'h10, push set {ch3..ch0}={4,3,2,1}, gnt=1 -> ram_en cycles t+1..t+4, addr 10,11,12,13 with data 1,2,3,4; done one cycle after addr 13 write; busy then 0.
- Push 3 sets back-to-back with DEPTH=2 and gnt=0 -> in_ready low after 2nd accept, 3rd set held. Raise gnt -> 8 consecutive writes; 3rd set accepted after first pop; 12 writes total, 3 done pulses.
- gnt toggles 1,0,0,1 mid-set -> address and data held while gnt=0; no skipped or duplicated address.
- Pointer at 8'hFE, push one set -> addresses FE,FF,00,01.
- Channel 0 = 18'h3FFFF -> ram_wdata 32'h0003FFFF without macro, 32'hFFFFFFFF with WB_SIGN_EXT_EN.
- Assert rst after 2 of 4 words written -> outputs return to reset values immediately; no done; next pushed set is written from address 0.

Source files
------------

// File: rtl/wb_seq.sv
// wb_seq: write-back sequencer. Buffers up to DEPTH result sets of NCH
// channel words and writes them one word per granted cycle into a
// single-port RAM at consecutive addresses from a loadable write pointer.
// Optional build macro: WB_SIGN_EXT_EN sign-extends each channel word to
// RAMW bits; without it the upper bits are zero.
module wb_seq #(
    parameter int NCH   = 4,
    parameter int DW    = 18,
    parameter int RAMW  = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    input  logic              base_load,
    input  logic [AW-1:0]     base_addr,
    input  logic              ram_gnt,
    output logic              ram_en,
    output logic [AW-1:0]     ram_addr,
    output logic [RAMW-1:0]   ram_wdata,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(NCH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state;
    logic [NCH*DW-1:0]       mem [DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [NW-1:0]           count;
    logic [CW-1:0]           idx;
    logic [AW-1:0]           wptr;
    logic                    push, commit, last, pop;

    function automatic logic [RAMW-1:0] widen(input logic [DW-1:0] w);
`ifdef WB_SIGN_EXT_EN
        return RAMW'($signed(w));
`else
        return RAMW'(w);
`endif
    endfunction

    function automatic logic [RAMW-1:0] chan_word(input logic [NCH*DW-1:0] set,
                                                  input logic [CW-1:0] c);
        return widen(set[int'(c)*DW +: DW]);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // No pop bypass: a full buffer refuses a set even while it drains.
    assign in_ready = (count != NW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign commit   = ram_en && ram_gnt;
    assign last     = (idx == CW'(NCH - 1));
    assign pop      = commit && last;
    assign busy     = (state == WRITE) || (count != '0);

    // Set storage; every read is gated by count, so contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Buffer bookkeeping, write FSM and registered RAM-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            idx       <= '0;
            wptr      <= '0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            count <= count + NW'(push) - NW'(pop);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            case (state)
                IDLE: begin
                    if (count == '0) begin
                        // A set pushed in this same cycle starts at the new base.
                        if (base_load) wptr <= base_addr;
                    end else begin
                        state     <= WRITE;
                        idx       <= '0;
                        ram_en    <= 1'b1;
                        ram_addr  <= wptr;
                        ram_wdata <= chan_word(mem[rd_ptr], '0);
                    end
                end
                WRITE: begin
                    if (commit) begin
                        wptr <= wptr + 1'b1;
                        if (!last) begin
                            idx       <= idx + 1'b1;
                            ram_addr  <= wptr + 1'b1;
                            ram_wdata <= chan_word(mem[rd_ptr], idx + 1'b1);
                        end else begin
                            rd_ptr <= ptr_inc(rd_ptr);
                            idx    <= '0;
                            done   <= 1'b1;
                            // Only sets already stored continue without a gap;
                            // one arriving on this edge starts via IDLE.
                            if (count > NW'(1)) begin
                                ram_addr  <= wptr + 1'b1;
                                ram_wdata <= chan_word(mem[ptr_inc(rd_ptr)], '0);
                            end else begin
                                ram_en <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_seq.sv
// tb_wb_seq: randomized self-checking bench for wb_seq against a
// transaction-level model (queue of pending RAM writes with their earliest
// issue cycle, set count, write pointer).
module tb_wb_seq;
    localparam int NCH = 4, DW = 18, RAMW = 32, AW = 8, DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCH*DW-1:0] in_data = '0;
    logic              base_load = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic              ram_gnt;
    logic              ram_en;
    logic [AW-1:0]     ram_addr;
    logic [RAMW-1:0]   ram_wdata;
    logic              busy;
    logic              done;

    wb_seq #(.NCH(NCH), .DW(DW), .RAMW(RAMW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .base_load(base_load), .base_addr(base_addr),
        .ram_gnt(ram_gnt), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0]   addr;
        logic [RAMW-1:0] data;
        int              avail;
        bit              last;
    } wr_t;

    wr_t           q[$];
    wr_t           e;
    int            cyc = 0;
    int            nsets = 0;
    logic [AW-1:0] mptr = '0;
    bit            done_exp = 0;
    bit            en_exp;
    int            obs_done = 0, obs_commit = 0;

    function automatic logic [RAMW-1:0] ext(input logic [DW-1:0] w);
`ifdef WB_SIGN_EXT_EN
        return w[DW-1] ? {{(RAMW-DW){1'b1}}, w} : {{(RAMW-DW){1'b0}}, w};
`else
        return {{(RAMW-DW){1'b0}}, w};
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ram_en", 32'(ram_en), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_ram_wdata", ram_wdata, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            q.delete();
            nsets    = 0;
            mptr     = '0;
            done_exp = 0;
        end else begin
            en_exp = (q.size() > 0) && (q[0].avail <= cyc);
            chk("ram_en", 32'(ram_en), 32'(en_exp));
            if (en_exp) begin
                chk("ram_addr", 32'(ram_addr), 32'(q[0].addr));
                chk("ram_wdata", ram_wdata, q[0].data);
            end
            chk("in_ready", 32'(in_ready), 32'(nsets < DEPTH));
            chk("busy", 32'(busy), 32'(nsets != 0));
            chk("done", 32'(done), 32'(done_exp));
            if (done) obs_done++;
            if (ram_en && ram_gnt) obs_commit++;
            done_exp = 0;
            if (base_load && nsets == 0) mptr = base_addr;
            if (in_valid && nsets < DEPTH) begin
                for (int k = 0; k < NCH; k++) begin
                    e.addr  = mptr;
                    e.data  = ext(in_data[k*DW +: DW]);
                    e.avail = cyc + 2;
                    e.last  = (k == NCH - 1);
                    q.push_back(e);
                    mptr = mptr + 1'b1;
                end
                nsets++;
            end
            if (en_exp && ram_gnt) begin
                e = q.pop_front();
                if (e.last) begin
                    nsets--;
                    done_exp = 1;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    int gnt_mode  = 0;     // 0: gnt_force, 1: random
    bit gnt_force = 1'b0;

    initial begin
        ram_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ram_gnt = (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : gnt_force;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [NCH*DW-1:0] d, input bit ld, input logic [AW-1:0] ba);
        bit acc;
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        base_load = ld;
        base_addr = ba;
        acc = 0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            base_load = 1'b0;
            n++;
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || nsets != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 3000), 32'd1);
        tick();
        tick();
    endtask

    function automatic logic [NCH*DW-1:0] mkset(input logic [DW-1:0] c3, input logic [DW-1:0] c2,
                                                input logic [DW-1:0] c1, input logic [DW-1:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [NCH*DW-1:0] rndset();
        logic [NCH*DW-1:0] d;
        d[31:0]  = $urandom();
        d[63:32] = $urandom();
        d[71:64] = 8'($urandom());
        return d;
    endfunction

    initial begin
        int d0, c0;
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int d0, c0;
        logic [NCH*DW-1:0] s;
        bit pat [7] = '{1, 0, 0, 1, 1, 1, 1};

        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single set from base 0x10
        gnt_force = 1'b1;
        tick();
        d0 = obs_done;
        c0 = obs_commit;
        push_set(mkset(18'd4, 18'd3, 18'd2, 18'd1), 1'b1, 8'h10);
        wait_idle();
        chk("t1_done_cnt", 32'(obs_done - d0), 32'd1);
        chk("t1_commits", 32'(obs_commit - c0), 32'd4);
        chk("t1_busy", 32'(busy), 32'd0);

        // Three sets against a full buffer with the grant held off
        gnt_force = 1'b0;
        tick();
        d0 = obs_done;
        c0 = obs_commit;
        fork
            begin
                push_set(mkset(18'h13, 18'h12, 18'h11, 18'h10), 1'b0, '0);
                push_set(mkset(18'h23, 18'h22, 18'h21, 18'h20), 1'b0, '0);
                push_set(mkset(18'h33, 18'h32, 18'h31, 18'h30), 1'b0, '0);
            end
            begin
                repeat (8) tick();
                chk("t2_ready_low", 32'(in_ready), 32'd0);
                chk("t2_no_commit", 32'(obs_commit - c0), 32'd0);
                gnt_force = 1'b1;
            end
        join
        wait_idle();
        chk("t2_done_cnt", 32'(obs_done - d0), 32'd3);
        chk("t2_commits", 32'(obs_commit - c0), 32'd12);

        // Grant toggling mid-set
        c0 = obs_commit;
        push_set(mkset(18'h4D, 18'h4C, 18'h4B, 18'h4A), 1'b0, '0);
        tick();
        foreach (pat[i]) begin
            gnt_force = pat[i];
            tick();
        end
        gnt_force = 1'b1;
        wait_idle();
        chk("t3_commits", 32'(obs_commit - c0), 32'd4);

        // Pointer wrap at 0xFE
        c0 = obs_commit;
        push_set(mkset(18'h5, 18'h6, 18'h7, 18'h8), 1'b1, 8'hFE);
        wait_idle();
        chk("t4_commits", 32'(obs_commit - c0), 32'd4);

        // All-ones channel 0 exercises the upper-bit fill
        push_set(mkset(18'h1, 18'h20000, 18'h0, 18'h3FFFF), 1'b0, '0);
        wait_idle();

        // Reset after two of four words
        c0 = obs_commit;
        d0 = obs_done;
        push_set(mkset(18'h99, 18'h98, 18'h97, 18'h96), 1'b1, 8'h40);
        for (int n = 0; n < 50 && (obs_commit - c0) < 2; n++) tick();
        chk("t6_two_written", 32'(obs_commit - c0), 32'd2);
        rst = 1'b0;
        #1;
        chk("t6_rst_en", 32'(ram_en), 32'd0);
        chk("t6_rst_addr", 32'(ram_addr), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        chk("t6_no_done", 32'(obs_done - d0), 32'd0);
        rst = 1'b1;
        tick();
        push_set(mkset(18'hA3, 18'hA2, 18'hA1, 18'hA0), 1'b0, '0);
        wait_idle();

        // Randomized traffic: random grant, gaps, base loads (often ignored)
        gnt_mode = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            s = rndset();
            push_set(s, ($urandom_range(0, 3) == 0), 8'($urandom()));
            if ($urandom_range(0, 15) == 0) wait_idle();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
